muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide unit with HI/LO result registers, sequenced by a small FSM.

---
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV via op[0].
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        count;
    logic                 accept, last_iter;
    logic                 is_div, neg_lo, neg_hi, b_zero;
    logic [WIDTH-1:0]     opb, work_hi, work_lo;
    logic                 signed_mode, sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   prod, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
    assign signed_mode = op[0];
`else
    logic unused_op0;
    assign signed_mode = 1'b0;
    assign unused_op0  = op[0];
`endif

    // Operands enter the iteration as magnitudes; signs are reapplied in FIXUP.
    assign sign_a = signed_mode & a[WIDTH-1];
    assign sign_b = signed_mode & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    assign mul_addend = work_lo[0] ? opb : '0;
    assign mul_sum    = {1'b0, work_hi} + {1'b0, mul_addend};
    assign div_shift  = {work_hi, work_lo[WIDTH-1]};
    assign div_ge     = div_shift >= {1'b0, opb};
    assign div_rem    = div_ge ? (div_shift[WIDTH-1:0] - opb) : div_shift[WIDTH-1:0];

    assign prod     = {work_hi, work_lo};
    assign prod_fix = neg_lo ? -prod : prod;
    // Remainder of x/0 is |x| re-signed by x, which restores the original dividend.
    assign quo_fix  = b_zero ? '1 : (neg_lo ? -work_lo : work_lo);
    assign rem_fix  = neg_hi ? -work_hi : work_hi;

    assign stall = busy & rd_req;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ITER;
                end
            end
            ITER: begin
                if (count == CW'(WIDTH - 1)) begin
                    last_iter  = 1'b1;
                    state_next = FIXUP;
                end
            end
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            b_zero  <= 1'b0;
            opb     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                is_div  <= op[1];
                b_zero  <= op[1] & (b == '0);
                div0    <= 1'b0;
                count   <= '0;
                neg_lo  <= sign_a ^ sign_b;
                neg_hi  <= sign_a;
                work_hi <= '0;
                work_lo <= op[1] ? mag_a : mag_b;
                opb     <= op[1] ? mag_b : mag_a;
            end else if (state == ITER) begin
                count <= last_iter ? '0 : count + 1'b1;
                if (is_div) begin
                    work_hi <= div_rem;
                    work_lo <= {work_lo[WIDTH-2:0], div_ge};
                end else begin
                    {work_hi, work_lo} <= {mul_sum, work_lo[WIDTH-1:1]};
                end
            end else if (state == FIXUP) begin
                done <= 1'b1;
                if (is_div) begin
                    hi   <= rem_fix;
                    lo   <= quo_fix;
                    div0 <= b_zero;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every cycle plus directed literals.
// Honours MULDIV_SIGNED_EN the same way as the design.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, rd_req;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, stall, div0;
    logic [W-1:0]  hi, lo;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_req(rd_req), .busy(busy), .done(done), .stall(stall),
        .hi(hi), .lo(lo), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {div0, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model_result(input logic [1:0] o, input logic [31:0] x,
                                                  input logic [31:0] y);
        logic        sgn;
        logic [63:0] p;
        longint      sx, sy;
        int          q, r;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        if (!o[1]) begin
            if (sgn) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
            end else begin
                p = {32'b0, x} * {32'b0, y};
            end
            return {1'b0, p};
        end
        if (y == 32'h0) return {1'b1, x, 32'hFFFFFFFF};
        if (sgn) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {1'b0, 32'(r), 32'(q)};
        end
        return {1'b0, x % y, x / y};
    endfunction

    logic         m_busy = 1'b0, m_done = 1'b0, m_div0 = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [64:0]  pend = '0;
    int           m_left = 0;

    // Timing model: accepted op occupies W+1 edges, results appear at the last one.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_div0 <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_div0, m_hi, m_lo} <= pend;
                end
            end else if (start) begin
                pend   <= model_result(op, a, b);
                m_left <= W + 1;
                m_busy <= 1'b1;
                m_div0 <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  64'(busy),  64'(m_busy));
            check("done",  64'(done),  64'(m_done));
            check("stall", 64'(stall), 64'(m_busy & rd_req));
            check("hi",    64'(hi),    64'(m_hi));
            check("lo",    64'(lo),    64'(m_lo));
            check("div0",  64'(div0),  64'(m_div0));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int sc);
        cyc = 0; sc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (stall === 1'b1) sc++;
            step();
            cyc++;
        end
        check("done_seen", 64'(done), 64'(1));
    endtask

    int  cyc, sc;
    logic seen;

    initial begin
        reset = 1'b1; start = 1'b0; rd_req = 1'b0; op = '0; a = '0; b = '0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo", {hi, lo}, 64'(0));
        check("rst_div0", 64'(div0), 64'(0));
        reset = 1'b0;
        step();

        start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, sc);
        check("multu_max_lat", 64'(cyc), 64'(W + 1));
        check("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
        check("multu_max_lo", 64'(lo), 64'h00000001);
        step();
        check("done_one_cycle", 64'(done), 64'(0));

        rd_req = 1'b1;
        start_op(2'b10, 32'd100, 32'd7);
        wait_done(cyc, sc);
        check("divu_stall_cycles", 64'(sc), 64'(W + 1));
        check("divu_stall_done", 64'(stall), 64'(0));
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        check("divu_div0", 64'(div0), 64'(0));
        rd_req = 1'b0;
        step();

        start_op(2'b10, 32'd5, 32'd0);
        wait_done(cyc, sc);
        check("div0_lat", 64'(cyc), 64'(W + 1));
        check("div0_lo", 64'(lo), 64'hFFFFFFFF);
        check("div0_hi", 64'(hi), 64'd5);
        check("div0_flag", 64'(div0), 64'(1));
        step();

        start_op(2'b00, 32'd6, 32'd7);
        repeat (4) step();
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        step();
        start = 1'b0;
        wait_done(cyc, sc);
        check("ignored_start_lo", 64'(lo), 64'd42);
        check("ignored_start_hi", 64'(hi), 64'd0);
        check("div0_cleared", 64'(div0), 64'(0));

        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0;
        check("back2back_done_drop", 64'(done), 64'(0));
        check("back2back_busy", 64'(busy), 64'(1));
        wait_done(cyc, sc);
        check("back2back_lat", 64'(cyc), 64'(W + 1));
        check("back2back_lo", 64'(lo), 64'd14);
        step();

        start_op(2'b00, 32'd3, 32'd4);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hilo", {hi, lo}, 64'(0));
        seen = 1'b0;
        repeat (40) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'(0));

`ifdef MULDIV_SIGNED_EN
        start_op(2'b01, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc, sc);
        check("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFFFFF1);
        step();
        start_op(2'b11, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, sc);
        check("div_neg_lat", 64'(cyc), 64'(W + 1));
        check("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFFFFFF);
        step();
        start_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, sc);
        check("div_ovf_lo", 64'(lo), 64'h80000000);
        check("div_ovf_hi", 64'(hi), 64'h0);
        check("div_ovf_div0", 64'(div0), 64'(0));
        step();
`else
        start_op(2'b11, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, sc);
        check("div_unsigned_lat", 64'(cyc), 64'(W + 1));
        check("div_unsigned_lo", 64'(lo), 64'h7FFFFFFC);
        check("div_unsigned_hi", 64'(hi), 64'h1);
        step();
        start_op(2'b01, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc, sc);
        check("mult_unsigned_hi", 64'(hi), 64'h4);
        check("mult_unsigned_lo", 64'(lo), 64'hFFFFFFF1);
        step();
`endif
        start_op(2'b10, 32'h12345678, 32'h00000100);
        wait_done(cyc, sc);
        check("divu_shift_lo", 64'(lo), 64'h00123456);
        check("divu_shift_hi", 64'(hi), 64'h00000078);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
